// File: rtl/sync_size_down_fifo_pkg.sv
// Shared sizing helpers for the size-down FIFO: lane bits, word widths, depth and pointer widths.
package sync_size_down_fifo_pkg;

    localparam int SDF_RD_WIDTH_DEF   = 16;
    localparam int SDF_RATIO_DEF      = 2;
    localparam int SDF_ADDR_WIDTH_DEF = 10;

    function automatic int sdf_lane_bits(input int ratio);
        return (ratio <= 1) ? 0 : $clog2(ratio);
    endfunction

    function automatic int sdf_wr_width(input int rd_width, input int ratio);
        return rd_width * ratio;
    endfunction

    function automatic int sdf_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int sdf_wr_ptr_w(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int sdf_rd_ptr_w(input int addr_width, input int ratio);
        return addr_width + sdf_lane_bits(ratio) + 1;
    endfunction

endpackage

// File: rtl/sync_size_down_fifo_dp_ram.sv
// sdf_dp_ram: simple dual-port RAM, one write port, one registered read port.
module sdf_dp_ram #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register resets so the FIFO read port comes up at zero; storage does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_size_down_fifo.sv
// Synchronous FIFO that accepts RATIO lanes per write word and returns one lane per read.
// Optional macro SDF_OUT_REG_EN adds an output register (read latency 2 instead of 1).
module sync_size_down_fifo
    import sync_size_down_fifo_pkg::*;
#(
    parameter int RD_WIDTH         = SDF_RD_WIDTH_DEF,
    parameter int RATIO            = SDF_RATIO_DEF,
    parameter int ADDR_WIDTH       = SDF_ADDR_WIDTH_DEF,
    parameter int ALMOST_FULL_NUM  = 620,
    parameter int ALMOST_EMPTY_NUM = 4,
    localparam int WR_WIDTH  = sdf_wr_width(RD_WIDTH, RATIO),
    localparam int LANE_BITS = sdf_lane_bits(RATIO),
    localparam int DEPTH     = sdf_depth(ADDR_WIDTH),
    localparam int WPW       = sdf_wr_ptr_w(ADDR_WIDTH),
    localparam int RPW       = sdf_rd_ptr_w(ADDR_WIDTH, RATIO)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WR_WIDTH-1:0] wr_data,
    input  logic                wr_en,
    output logic                full,
    output logic                almost_full,
    output logic [WPW-1:0]      wr_water_level,
    output logic                overflow,
    input  logic                rd_en,
    output logic [RD_WIDTH-1:0] rd_data,
    output logic                rd_valid,
    output logic                empty,
    output logic                almost_empty,
    output logic [RPW-1:0]      rd_water_level,
    output logic                underflow
);

    localparam int LW = (LANE_BITS > 0) ? LANE_BITS : 1;

    localparam logic [WPW-1:0] WP_ONE   = WPW'(1);
    localparam logic [RPW-1:0] RP_ONE   = RPW'(1);
    localparam logic [WPW-1:0] FULL_LVL = WPW'(DEPTH);
    localparam logic [WPW-1:0] AF_TH    = WPW'(ALMOST_FULL_NUM);
    localparam logic [RPW-1:0] AE_TH    = RPW'(ALMOST_EMPTY_NUM);
    localparam logic [RPW-1:0] RATIO_RP = RPW'(RATIO);

    logic [WPW-1:0]      wr_ptr;
    logic [WPW-1:0]      wr_ptr_nxt;
    logic [RPW-1:0]      rd_ptr;
    logic [RPW-1:0]      rd_ptr_nxt;
    logic [WPW-1:0]      wr_lvl_nxt;
    logic [RPW-1:0]      rd_lvl_nxt;
    logic                wr_acc;
    logic                rd_acc;
    logic [WR_WIDTH-1:0] ram_q_p1;
    logic [LW-1:0]       lane_p1;
    logic                vld_p1;
    logic [RD_WIDTH-1:0] lane_data_p1;

    // Acceptance is judged on registered flags, so a full FIFO never takes a write in the cycle a read frees a slot.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        wr_ptr_nxt = wr_acc ? (wr_ptr + WP_ONE) : wr_ptr;
        rd_ptr_nxt = rd_acc ? (rd_ptr + RP_ONE) : rd_ptr;
        // A partially drained word keeps its slot: only whole consumed words leave the write-side level.
        wr_lvl_nxt = wr_ptr_nxt - rd_ptr_nxt[LANE_BITS +: WPW];
        rd_lvl_nxt = (RPW'(wr_ptr_nxt) << LANE_BITS) - rd_ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            wr_water_level <= '0;
            rd_water_level <= '0;
            full           <= 1'b0;
            almost_full    <= 1'b0;
            empty          <= 1'b1;
            almost_empty   <= 1'b1;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            wr_water_level <= wr_lvl_nxt;
            rd_water_level <= rd_lvl_nxt;
            full           <= (wr_lvl_nxt == FULL_LVL);
            almost_full    <= (wr_lvl_nxt >= AF_TH);
            empty          <= (rd_lvl_nxt == '0);
            almost_empty   <= (rd_lvl_nxt <= AE_TH);
            overflow       <= wr_en & full;
            underflow      <= rd_en & empty;
        end
    end

    sdf_dp_ram #(
        .WIDTH      (WR_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[LANE_BITS +: ADDR_WIDTH]),
        .rd_data (ram_q_p1)
    );

    // Stage p1: RAM word registered; lane select travels alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) begin
                lane_p1 <= LW'(rd_ptr % RATIO_RP);
            end
        end
    end

    assign lane_data_p1 = ram_q_p1[int'(lane_p1) * RD_WIDTH +: RD_WIDTH];

`ifdef SDF_OUT_REG_EN
    logic [RD_WIDTH-1:0] rd_data_p2;
    logic                vld_p2;

    // Stage p2: selected lane registered once more.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p2 <= '0;
            vld_p2     <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                rd_data_p2 <= lane_data_p1;
            end
        end
    end

    assign rd_data  = rd_data_p2;
    assign rd_valid = vld_p2;
`else
    assign rd_data  = lane_data_p1;
    assign rd_valid = vld_p1;
`endif

endmodule

// File: tb/tb_sync_size_down_fifo.sv
// Self-checking bench for sync_size_down_fifo (RD_WIDTH=16, RATIO=4, ADDR_WIDTH=4).
module tb_sync_size_down_fifo;

    localparam int RDW = 16;
    localparam int RAT = 4;
    localparam int AW  = 4;

    logic            clk_tb;
    logic            tb_rst;
    logic [63:0]     wr_data;
    logic            wr_en;
    logic            full;
    logic            almost_full;
    logic [4:0]      wr_water_level;
    logic            overflow;
    logic            rd_en;
    logic [15:0]     rd_data;
    logic            rd_valid;
    logic            empty;
    logic            almost_empty;
    logic [6:0]      rd_water_level;
    logic            underflow;

    int checks   = 0;
    int failures = 0;

    logic [15:0] lane_q [$];
    logic [15:0] exp_q  [$];
    int          m_wr = 0;
    int          m_rd = 0;

    sync_size_down_fifo #(
        .RD_WIDTH         (RDW),
        .RATIO            (RAT),
        .ADDR_WIDTH       (AW),
        .ALMOST_FULL_NUM  (12),
        .ALMOST_EMPTY_NUM (4)
    ) dut (
        .clk            (clk_tb),
        .rst            (tb_rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .full           (full),
        .almost_full    (almost_full),
        .wr_water_level (wr_water_level),
        .overflow       (overflow),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .empty          (empty),
        .almost_empty   (almost_empty),
        .rd_water_level (rd_water_level),
        .underflow      (underflow)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Drive one cycle; the expected lane stream is queued for every read the FIFO should accept.
    task automatic cycle(input logic we, input logic [63:0] wd, input logic re);
        bit w_ok;
        bit r_ok;
        w_ok = we && ((m_wr - m_rd / RAT) != (1 << AW));
        r_ok = re && ((m_wr * RAT - m_rd) != 0);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        if (r_ok) begin
            exp_q.push_back(lane_q.pop_front());
            m_rd++;
        end
        if (w_ok) begin
            for (int l = 0; l < RAT; l++) lane_q.push_back(wd[l*RDW +: RDW]);
            m_wr++;
        end
        @(posedge clk_tb);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset(input logic we, input logic re);
        tb_rst  = 1'b1;
        wr_en   = we;
        rd_en   = re;
        wr_data = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk_tb);
        #1;
        tb_rst = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        lane_q.delete();
        m_wr = 0;
        m_rd = 0;
    endtask

    // Monitor: every presented read word is matched against the scoreboard.
    always @(negedge clk_tb) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no rd_valid", rd_data);
            end else begin
                check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        tb_rst  = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        repeat (2) @(posedge clk_tb);
        #1;
        do_reset(1'b0, 1'b0);

        check("rst_empty", int'(empty), 1);
        check("rst_almost_empty", int'(almost_empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_almost_full", int'(almost_full), 0);
        check("rst_wr_lvl", int'(wr_water_level), 0);
        check("rst_rd_lvl", int'(rd_water_level), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_flow", int'({overflow, underflow}), 0);

        // One word, four lanes out in lane order.
        cycle(1'b1, 64'h0004_0003_0002_0001, 1'b0);
        check("w1_rd_lvl", int'(rd_water_level), 4);
        check("w1_wr_lvl", int'(wr_water_level), 1);
        check("w1_empty", int'(empty), 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        check("r4_empty", int'(empty), 1);
        check("r4_wr_lvl", int'(wr_water_level), 0);
        cycle(1'b0, '0, 1'b0);
        check("idle_rd_valid", int'(rd_valid), 0);
        check("idle_rd_data_hold", int'(rd_data), 16'h0004);

        // Read and write together on an empty FIFO: read refused, no bypass.
        cycle(1'b1, 64'h0008_0007_0006_0005, 1'b1);
        check("uf_pulse", int'(underflow), 1);
        check("uf_rd_valid", int'(rd_valid), 0);
        check("uf_empty", int'(empty), 0);
        check("uf_rd_lvl", int'(rd_water_level), 4);
        cycle(1'b0, '0, 1'b0);
        check("uf_pulse_end", int'(underflow), 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
        check("drain_empty", int'(empty), 1);

        // Fill to full across the RAM address wrap, with almost_full threshold.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, {16'(i*4+3), 16'(i*4+2), 16'(i*4+1), 16'(i*4+0)} + 64'h1000_1000_1000_1000, 1'b0);
            if (i == 10) check("af_at_11", int'(almost_full), 0);
            if (i == 11) check("af_at_12", int'(almost_full), 1);
        end
        check("fill_full", int'(full), 1);
        check("fill_wr_lvl", int'(wr_water_level), 16);
        check("fill_rd_lvl", int'(rd_water_level), 64);
        cycle(1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
        check("ovf_pulse", int'(overflow), 1);
        check("ovf_wr_lvl", int'(wr_water_level), 16);
        check("ovf_rd_lvl", int'(rd_water_level), 64);
        cycle(1'b0, '0, 1'b0);
        check("ovf_pulse_end", int'(overflow), 0);

        // Partial word keeps its slot; a write alongside the freeing read is refused.
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        check("p3_full", int'(full), 1);
        check("p3_rd_lvl", int'(rd_water_level), 61);
        check("p3_wr_lvl", int'(wr_water_level), 16);
        cycle(1'b1, 64'hBAD1_BAD1_BAD1_BAD1, 1'b1);
        check("p4_overflow", int'(overflow), 1);
        check("p4_full", int'(full), 0);
        check("p4_wr_lvl", int'(wr_water_level), 15);
        check("p4_rd_lvl", int'(rd_water_level), 60);

        // Drain to the almost_empty threshold.
        for (int i = 0; i < 55; i++) cycle(1'b0, '0, 1'b1);
        check("ae_at_5_lvl", int'(rd_water_level), 5);
        check("ae_at_5", int'(almost_empty), 0);
        cycle(1'b0, '0, 1'b1);
        check("ae_at_4_lvl", int'(rd_water_level), 4);
        check("ae_at_4", int'(almost_empty), 1);

        // Accepted write and read in the same cycle.
        cycle(1'b1, 64'h2004_2003_2002_2001, 1'b1);
        check("wr_rd_rd_lvl", int'(rd_water_level), 7);
        check("wr_rd_wr_lvl", int'(wr_water_level), 2);

        // Reset with ten words stored; requests in the reset cycle are ignored.
        for (int i = 0; i < 8; i++) cycle(1'b1, 64'h3000_3000_3000_3000 + 64'(i), 1'b0);
        check("pre_rst_wr_lvl", int'(wr_water_level), 10);
        do_reset(1'b1, 1'b1);
        check("mrst_empty", int'(empty), 1);
        check("mrst_full", int'(full), 0);
        check("mrst_wr_lvl", int'(wr_water_level), 0);
        check("mrst_rd_lvl", int'(rd_water_level), 0);
        check("mrst_rd_valid", int'(rd_valid), 0);
        cycle(1'b0, '0, 1'b1);
        check("mrst_underflow", int'(underflow), 1);
        check("mrst_rd_valid2", int'(rd_valid), 0);

        repeat (3) cycle(1'b0, '0, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
